// File: rtl/lampada_pkg.sv
// Shared types for the lamp controller: FSM state encoding, default debounce length
// and the Moore lamp decode.
package lampada_pkg;

  typedef enum logic [2:0] {
    OFF_IDLE = 3'd0,
    OFF_DEB  = 3'd1,
    ON_HOLD  = 3'd2,
    ON_IDLE  = 3'd3,
    ON_DEB   = 3'd4,
    OFF_HOLD = 3'd5
  } lamp_state_t;

  localparam int DEBOUNCE_T_DEFAULT = 300;

  function automatic logic lamp_on(input lamp_state_t s);
    case (s)
      ON_HOLD, ON_IDLE, ON_DEB: lamp_on = 1'b1;
      default:                  lamp_on = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/contador_debounce.sv
// Saturating debounce counter. clr forces the count to 0, or to 1 when inc is also set,
// so a new debounce window can start on the same edge that closes the old one.
module contador_debounce
  import lampada_pkg::*;
#(
  parameter int N = DEBOUNCE_T_DEFAULT,
  localparam int W = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic         done,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = W'(1);
  localparam logic [W-1:0] CNT_LAST = W'(N - 1);
  localparam logic [W-1:0] CNT_MAX  = W'(N);

  logic [W-1:0] cnt_r;

  // Count register: load, saturating increment or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (clr) begin
      cnt_r <= inc ? CNT_ONE : CNT_ZERO;
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == CNT_LAST);
  assign cnt  = cnt_r;

endmodule

// File: rtl/controle_lampada.sv
// Push-button lamp toggle with debounce and forced shutdown from the auto-shutdown timer.
// Optional macro CONTROLE_LAMPADA_SYNC_EN inserts a 2-flop synchronizer on push.
module controle_lampada
  import lampada_pkg::*;
#(
  parameter int DEBOUNCE_T = DEBOUNCE_T_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic C,
  output logic L,
  output logic enable_timer
);

  localparam int CNT_W = $clog2(DEBOUNCE_T + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_T - 1);

  logic             push_s;
  logic             clr_s;
  logic             inc_s;
  logic             done_s;
  logic             cnt_bad_s;
  logic [CNT_W-1:0] cnt_s;
  lamp_state_t      state_r;
  lamp_state_t      next_s;
  lamp_state_t      shut_s;
  logic             lamp_r;

`ifdef CONTROLE_LAMPADA_SYNC_EN
  logic [1:0] sync_r;

  // Two-stage synchronizer for the raw button level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], push};
    end
  end

  assign push_s = sync_r[1];
`else
  assign push_s = push;
`endif

  contador_debounce #(.N(DEBOUNCE_T)) u_contador (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .inc  (inc_s),
    .done (done_s),
    .cnt  (cnt_s)
  );

  // A count past the qualification point cannot occur in a debounce state; treat it as a glitch.
  assign cnt_bad_s = (cnt_s > CNT_LAST);
  assign shut_s    = push_s ? OFF_HOLD : OFF_IDLE;

  // State register and registered lamp drive decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= OFF_IDLE;
      lamp_r  <= 1'b0;
    end else begin
      state_r <= next_s;
      lamp_r  <= lamp_on(next_s);
    end
  end

  // Next-state logic; the counter is held clear except while a debounce window is open.
  always_comb begin
    next_s = OFF_IDLE;
    clr_s  = 1'b1;
    inc_s  = 1'b0;
    case (state_r)
      OFF_IDLE: begin
        if (push_s) begin
          next_s = OFF_DEB;
          inc_s  = 1'b1;
        end else begin
          next_s = OFF_IDLE;
        end
      end
      OFF_DEB: begin
        if (!push_s || cnt_bad_s) begin
          next_s = OFF_IDLE;
        end else if (done_s) begin
          next_s = ON_HOLD;
        end else begin
          next_s = OFF_DEB;
          clr_s  = 1'b0;
          inc_s  = 1'b1;
        end
      end
      ON_HOLD: begin
        if (C) begin
          next_s = shut_s;
        end else if (!push_s) begin
          next_s = ON_IDLE;
        end else begin
          next_s = ON_HOLD;
        end
      end
      ON_IDLE: begin
        if (C) begin
          next_s = shut_s;
        end else if (push_s) begin
          next_s = ON_DEB;
          inc_s  = 1'b1;
        end else begin
          next_s = ON_IDLE;
        end
      end
      ON_DEB: begin
        // Shutdown wins even on the edge that would qualify the press.
        if (C) begin
          next_s = shut_s;
        end else if (!push_s || cnt_bad_s) begin
          next_s = ON_IDLE;
        end else if (done_s) begin
          next_s = OFF_HOLD;
        end else begin
          next_s = ON_DEB;
          clr_s  = 1'b0;
          inc_s  = 1'b1;
        end
      end
      OFF_HOLD: begin
        if (!push_s) begin
          next_s = OFF_IDLE;
        end else begin
          next_s = OFF_HOLD;
        end
      end
      default: begin
        next_s = OFF_IDLE;
      end
    endcase
  end

  assign L            = lamp_r;
  assign enable_timer = lamp_r;

endmodule

// File: tb/tb_controle_lampada.sv
// Self-checking bench for controle_lampada (DEBOUNCE_T=4), directed scenarios plus
// randomized push/C traffic against a behavioural press-counting model.
module tb_controle_lampada;

  localparam int T = 4;
`ifdef CONTROLE_LAMPADA_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif
  localparam int LAT = T + SD;

  logic clk = 1'b0;
  logic rst;
  logic push;
  logic C;
  logic L;
  logic enable_timer;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: lamp level, consecutive-high run, whether a new press may count.
  bit m_lamp;
  int m_run;
  bit m_armed;
  bit m_d1;
  bit m_d2;

  always #5 clk = ~clk;

  controle_lampada #(.DEBOUNCE_T(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .C            (C),
    .L            (L),
    .enable_timer (enable_timer)
  );

  function automatic void model_reset();
    m_lamp  = 1'b0;
    m_run   = 0;
    m_armed = 1'b1;
    m_d1    = 1'b0;
    m_d2    = 1'b0;
  endfunction

  function automatic void model_step(input bit p, input bit c);
    bit eff;
    if (SD == 0) begin
      eff = p;
    end else begin
      eff  = m_d2;
      m_d2 = m_d1;
      m_d1 = p;
    end
    if (m_lamp && c) begin
      m_lamp  = 1'b0;
      m_run   = 0;
      m_armed = !eff;
    end else if (!eff) begin
      m_run   = 0;
      m_armed = 1'b1;
    end else if (m_armed) begin
      m_run = m_run + 1;
      if (m_run == T) begin
        m_lamp  = !m_lamp;
        m_run   = 0;
        m_armed = 1'b0;
      end
    end
  endfunction

  task automatic drive(input logic p, input logic c);
    push = p;
    C    = c;
    @(posedge clk);
    model_step(p, c);
    #1;
  endtask

  task automatic apply_reset();
    push = 1'b0;
    C    = 1'b0;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic lamp_on_then_release();
    repeat (LAT) drive(1'b1, 1'b0);
    repeat (SD + 2) drive(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic want;
    rst  = 1'b1;
    push = 1'b1;
    C    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (L !== 1'b0 || enable_timer !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: L=%b enable_timer=%b expected 0", L, enable_timer);
    end
    rst = 1'b0;
    C   = 1'b0;
    model_reset();
    for (int i = 1; i <= LAT + 2; i++) begin
      drive(1'b1, 1'b0);
      want = (i >= LAT);
      n_checks++;
      if (L !== want || enable_timer !== want) begin
        n_fail++;
        $display("FAIL reset_fresh_press[%0d]: L=%b enable_timer=%b expected %b", i, L, enable_timer, want);
      end
    end
  endtask

  task automatic test_clean_press();
    logic want;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= 10; i++) begin
        drive(1'b1, 1'b0);
        want = (r == 0) ? (i >= LAT) : (i < LAT);
        n_checks++;
        if (L !== want || enable_timer !== want) begin
          n_fail++;
          $display("FAIL clean_press%0d[%0d]: L=%b enable_timer=%b expected %b", r, i, L, enable_timer, want);
        end
      end
      for (int i = 1; i <= 5; i++) begin
        drive(1'b0, 1'b0);
        want = (r == 0);
        n_checks++;
        if (L !== want) begin
          n_fail++;
          $display("FAIL clean_release%0d[%0d]: L=%b expected %b", r, i, L, want);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [9:0] pat;
    logic       want;
    pat = 10'b11_1111_0111;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(pat[i], 1'b0);
      want = (i >= 7 + SD);
      n_checks++;
      if (L !== want) begin
        n_fail++;
        $display("FAIL bounce[%0d]: L=%b expected %b", i, L, want);
      end
    end
  endtask

  task automatic test_shutdown();
    logic want;
    apply_reset();
    lamp_on_then_release();
    n_checks++;
    if (L !== 1'b1) begin
      n_fail++;
      $display("FAIL shutdown_on: L=%b expected 1", L);
    end
    drive(1'b0, 1'b1);
    n_checks++;
    if (L !== 1'b0 || enable_timer !== 1'b0) begin
      n_fail++;
      $display("FAIL shutdown_pulse: L=%b enable_timer=%b expected 0", L, enable_timer);
    end
    drive(1'b0, 1'b1);
    repeat (3) drive(1'b0, 1'b0);
    n_checks++;
    if (L !== 1'b0) begin
      n_fail++;
      $display("FAIL shutdown_ignored: L=%b expected 0", L);
    end
    for (int i = 1; i <= LAT; i++) begin
      drive(1'b1, 1'b0);
      want = (i >= LAT);
      n_checks++;
      if (L !== want) begin
        n_fail++;
        $display("FAIL shutdown_repress[%0d]: L=%b expected %b", i, L, want);
      end
    end
  endtask

  task automatic test_collision();
    logic want;
    apply_reset();
    lamp_on_then_release();
    repeat (LAT - 1) drive(1'b1, 1'b0);
    n_checks++;
    if (L !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_pre: L=%b expected 1", L);
    end
    drive(1'b1, 1'b1);
    n_checks++;
    if (L !== 1'b0 || enable_timer !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_c: L=%b enable_timer=%b expected 0", L, enable_timer);
    end
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 1'b0);
      n_checks++;
      if (L !== 1'b0) begin
        n_fail++;
        $display("FAIL collision_held[%0d]: L=%b expected 0", i, L);
      end
    end
    repeat (SD + 1) drive(1'b0, 1'b0);
    for (int i = 1; i <= LAT; i++) begin
      drive(1'b1, 1'b0);
      want = (i >= LAT);
      n_checks++;
      if (L !== want) begin
        n_fail++;
        $display("FAIL collision_repress[%0d]: L=%b expected %b", i, L, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic want;
    apply_reset();
    lamp_on_then_release();
    repeat (SD + 2) drive(1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (L !== 1'b0 || enable_timer !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: L=%b enable_timer=%b expected 0", L, enable_timer);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= LAT; i++) begin
      drive(1'b1, 1'b0);
      want = (i >= LAT);
      n_checks++;
      if (L !== want) begin
        n_fail++;
        $display("FAIL reset_mid_fresh[%0d]: L=%b expected %b", i, L, want);
      end
    end
  endtask

  task automatic test_random();
    logic p;
    logic c;
    apply_reset();
    p = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) p = !p;
      c = ($urandom_range(0, 15) == 0);
      drive(p, c);
      n_checks++;
      if (L !== m_lamp || enable_timer !== m_lamp) begin
        n_fail++;
        $display("FAIL random[%0d]: L=%b enable_timer=%b expected %b", i, L, enable_timer, m_lamp);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    push = 1'b0;
    C    = 1'b0;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_shutdown();
    test_collision();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
